// File: rtl/imm_logic_unit.sv
// Multi-cycle immediate-operand logic unit (ANDI/ORI/XORI/NORI/LUI).
// Private register file, IDLE->DECODE->EXEC->WB control, r0 hardwired to zero.
module imm_logic_unit #(
    parameter int WIDTH    = 32,
    parameter int IMM_W    = 16,
    parameter int NREG     = 32,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IMM_W+15:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              done,
    output logic              err,
    input  logic [4:0]        dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int IW = IMM_W + 16;

    localparam logic [5:0] OP_ANDI = 6'h0D;
    localparam logic [5:0] OP_ORI  = 6'h0E;
    localparam logic [5:0] OP_XORI = 6'h0F;
    localparam logic [5:0] OP_NORI = 6'h10;
    localparam logic [5:0] OP_LUI  = 6'h11;

    localparam logic [5:0] NREG_C = 6'(NREG);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t           state;
    logic [IW-1:0]    ir;
    logic [WIDTH-1:0] regs [32];
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;

    logic [5:0]       opc;
    logic [4:0]       rs;
    logic [4:0]       rd;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] lui_val;
    logic [WIDTH-1:0] alu;
    logic             op_ok;
    logic             legal;

    assign opc = ir[IW-1 -: 6];
    assign rs  = ir[IW-7 -: 5];
    assign rd  = ir[IW-12 -: 5];
    assign imm = ir[IMM_W-1:0];

    assign lui_val = WIDTH'(imm) << (WIDTH - IMM_W);

    // Immediate extension: sign bit or zero fills the upper bits.
    always_comb begin
        imm_ext = '0;
        imm_ext[IMM_W-1:0] = imm;
        for (int i = IMM_W; i < WIDTH; i++) begin
            imm_ext[i] = SIGN_EXT && imm[IMM_W-1];
        end
    end

    // Legality: known opcode and both register indices in range.
    always_comb begin
        op_ok = (opc == OP_ANDI) || (opc == OP_ORI) ||
                (opc == OP_XORI) || (opc == OP_NORI) ||
                (opc == OP_LUI);
        legal = op_ok &&
                ({1'b0, rs} < NREG_C) &&
                ({1'b0, rd} < NREG_C);
    end

    // Logic operation on the operands latched during DECODE.
    always_comb begin
        case (opc)
            OP_ANDI: alu = op_a & op_b;
            OP_ORI:  alu = op_a | op_b;
            OP_XORI: alu = op_a ^ op_b;
            OP_NORI: alu = ~(op_a | op_b);
            default: alu = lui_val;
        endcase
    end

    // Debug read port; out-of-range indices and r0 read as zero.
    always_comb begin
        dbg_data = '0;
        if (({1'b0, dbg_addr} < NREG_C) && (dbg_addr != 5'd0)) begin
            dbg_data = regs[dbg_addr];
        end
    end

    // Control FSM, datapath registers and register-file writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            ir          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir          <= instr;
                        state       <= DECODE;
                        instr_ready <= 1'b0;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        op_a  <= regs[rs];
                        op_b  <= imm_ext;
                        state <= EXEC;
                    end else begin
                        err         <= 1'b1;
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    result <= alu;
                    done   <= 1'b1;
                    state  <= WB;
                end
                default: begin
                    if (rd != 5'd0) begin
                        regs[rd] <= result;
                    end
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_logic_unit.sv
// Testbench for imm_logic_unit: three parameterisations, directed vectors,
// done/err events checked by a scoreboard monitor.
module tb_imm_logic_unit;

    typedef struct {
        int k;
        bit is_err;
        int due;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic [2:0]  vld = '0;
    logic [4:0]  dbg_addr = '0;
    logic [2:0]  rdy;
    logic [2:0]  dn;
    logic [2:0]  er;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [15:0] d2;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t sbq[$];
    ev_t mon_e;
    int  mon_k;

    imm_logic_unit u0 (
        .clk(clk), .reset(reset), .instr(instr),
        .instr_valid(vld[0]), .instr_ready(rdy[0]),
        .done(dn[0]), .err(er[0]),
        .dbg_addr(dbg_addr), .dbg_data(d0)
    );

    imm_logic_unit #(.SIGN_EXT(1'b0), .NREG(16)) u1 (
        .clk(clk), .reset(reset), .instr(instr),
        .instr_valid(vld[1]), .instr_ready(rdy[1]),
        .done(dn[1]), .err(er[1]),
        .dbg_addr(dbg_addr), .dbg_data(d1)
    );

    imm_logic_unit #(.WIDTH(16), .IMM_W(16)) u2 (
        .clk(clk), .reset(reset), .instr(instr),
        .instr_valid(vld[2]), .instr_ready(rdy[2]),
        .done(dn[2]), .err(er[2]),
        .dbg_addr(dbg_addr), .dbg_data(d2)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] enc(logic [5:0] op, logic [4:0] rs,
                                        logic [4:0] rd, logic [15:0] imm);
        return {op, rs, rd, imm};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic rdreg(int k, logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        case (k)
            0:       v = d0;
            1:       v = d1;
            default: v = {16'h0, d2};
        endcase
    endtask

    // Monitor: every done/err pulse must match the next expected event.
    initial forever begin
        @(negedge clk);
        if (!reset && ((dn | er) != 3'b000)) begin
            mon_k = 0;
            for (int i = 0; i < 3; i++) begin
                if (dn[i] || er[i]) mon_k = i;
            end
            checks++;
            if ((dn & er) != 3'b000) begin
                errors++;
                $display("FAIL done_err_overlap: done=%b err=%b, required never both", dn, er);
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: dut%0d done=%b err=%b cycle %0d, required none",
                         mon_k, dn, er, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.k != mon_k || mon_e.is_err != er[mon_k] || mon_e.due != cyc) begin
                    errors++;
                    $display("FAIL event: got dut%0d err=%0b cycle %0d, required dut%0d err=%0b cycle %0d",
                             mon_k, er[mon_k], cyc, mon_e.k, mon_e.is_err, mon_e.due);
                end
            end
        end
    end

    task automatic op(int k, logic [31:0] ins, bit is_err, bit hold,
                      logic [4:0] ra, logic [31:0] oldv, logic [31:0] newv);
        logic [31:0] v;
        int n;
        @(negedge clk);
        chk("ready_idle", {31'b0, rdy[k]}, 32'd1);
        instr = ins;
        vld = 3'b000;
        vld[k] = 1'b1;
        sbq.push_back('{k, is_err, cyc + (is_err ? 2 : 3)});
        n = is_err ? 1 : 3;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("ready_busy", {31'b0, rdy[k]}, 32'd0);
            if (!hold || i == n - 1) vld = 3'b000;
            if (!is_err && i == 2) begin
                rdreg(k, ra, v);
                chk("wb_old_value", v, oldv);
            end
        end
        for (int i = 0; i < 8 && (sbq.size() != 0 || !rdy[k]); i++) begin
            @(negedge clk);
        end
        if (sbq.size() != 0 || !rdy[k]) begin
            checks++;
            errors++;
            $display("FAIL timeout: dut%0d pending=%0d ready=%b, required event and ready",
                     k, sbq.size(), rdy[k]);
            sbq.delete();
        end
        rdreg(k, ra, v);
        chk("reg_value", v, newv);
    endtask

    initial begin
        logic [31:0] v;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", {31'b0, rdy[k]}, 32'd1);
            chk("reset_done", {31'b0, dn[k]}, 32'd0);
            chk("reset_err", {31'b0, er[k]}, 32'd0);
        end
        rdreg(0, 5'd15, v);
        chk("reset_r15", v, 32'h0);

        op(0, 32'h380FE756, 1'b0, 1'b0, 5'd15, 32'h0, 32'hFFFFE756);
        op(0, enc(6'h0D, 5'd15, 5'd4, 16'hA163), 1'b0, 1'b0, 5'd4, 32'h0, 32'hFFFFA142);
        op(0, enc(6'h0F, 5'd15, 5'd4, 16'hBB34), 1'b0, 1'b0, 5'd4, 32'hFFFFA142, 32'h00005C62);
        op(0, enc(6'h0E, 5'd15, 5'd18, 16'h21F0), 1'b0, 1'b1, 5'd18, 32'h0, 32'hFFFFE7F6);
        op(0, enc(6'h10, 5'd0, 5'd5, 16'h00FF), 1'b0, 1'b0, 5'd5, 32'h0, 32'hFFFFFF00);
        op(0, enc(6'h11, 5'd15, 5'd6, 16'h1234), 1'b0, 1'b0, 5'd6, 32'h0, 32'h12340000);
        op(0, enc(6'h0E, 5'd15, 5'd0, 16'hFFFF), 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        op(0, enc(6'h3F, 5'd0, 5'd15, 16'h0000), 1'b1, 1'b0, 5'd15, 32'hFFFFE756, 32'hFFFFE756);
        rdreg(0, 5'd4, v);
        chk("illegal_r4_kept", v, 32'h00005C62);

        @(negedge clk);
        instr = enc(6'h0E, 5'd0, 5'd7, 16'h1111);
        vld = 3'b001;
        @(negedge clk);
        chk("abort_busy", {31'b0, rdy[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vld = 3'b000;
        chk("abort_ready", {31'b0, rdy[0]}, 32'd1);
        chk("abort_done", {31'b0, dn[0]}, 32'd0);
        chk("abort_err", {31'b0, er[0]}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, dn[0]}, 32'd0);
        end
        rdreg(0, 5'd7, v);
        chk("abort_r7", v, 32'h0);
        rdreg(0, 5'd15, v);
        chk("abort_r15_reset", v, 32'h0);

        op(1, enc(6'h0E, 5'd0, 5'd7, 16'h8001), 1'b0, 1'b0, 5'd7, 32'h0, 32'h00008001);
        op(1, enc(6'h0E, 5'd0, 5'd20, 16'h1234), 1'b1, 1'b0, 5'd7, 32'h00008001, 32'h00008001);
        op(1, enc(6'h0D, 5'd17, 5'd7, 16'h0000), 1'b1, 1'b1, 5'd7, 32'h00008001, 32'h00008001);
        rdreg(1, 5'd20, v);
        chk("dbg_out_of_range", v, 32'h0);

        op(2, enc(6'h11, 5'd0, 5'd3, 16'hABCD), 1'b0, 1'b0, 5'd3, 32'h0, 32'h0000ABCD);
        op(2, enc(6'h0F, 5'd3, 5'd3, 16'hFFFF), 1'b0, 1'b0, 5'd3, 32'h0000ABCD, 32'h00005432);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
